// File: rtl/fwd_hzd_sb_unit_pkg.sv
// Shared constants for the forwarding / hazard unit: select encodings
// and the small helper that places the MDU select after the stage selects.
package fwd_hzd_sb_unit_pkg;

    // fwd_sel value meaning "read the register file, no bypass".
    localparam int SEL_RF = 0;

    // Stage k is reported as fwd_sel = k + SEL_STG_OFS.
    localparam int SEL_STG_OFS = 1;

    // The MDU result select sits just above the last stage select.
    function automatic int sel_mdu(input int num_fwd_stg);
        return num_fwd_stg + SEL_STG_OFS;
    endfunction

    // Hazard flags produced per operand by the lookup block.
    typedef struct packed {
        logic load_use;
        logic md_raw;
    } src_hzd_t;

endpackage

// File: rtl/fwd_hzd_sb_unit_src_lookup.sv
// One EX operand's bypass search: nearest matching stage wins, otherwise
// the MDU result when it is arriving, otherwise the register file.
// Also reports whether this operand causes a load-use or MDU RAW stall.
module fwd_hzd_sb_unit_src_lookup
    import fwd_hzd_sb_unit_pkg::*;
#(
    parameter int NUM_FWD_STG = 2,
    parameter int REG_AW      = 5,
    parameter int SEL_W       = 2
) (
    input  logic                          regread,
    input  logic [REG_AW-1:0]             srcaddr,
    input  logic [NUM_FWD_STG-1:0]        stg_regwrite,
    input  logic [NUM_FWD_STG*REG_AW-1:0] stg_wraddr,
    input  logic [NUM_FWD_STG-1:0]        stg_notready,
    input  logic                          md_busy,
    input  logic                          md_done,
    input  logic [REG_AW-1:0]             md_addr_q,
    output logic [SEL_W-1:0]              sel,
    output src_hzd_t                      hzd
);

    logic hit;

    // Priority search over younger stages, then MDU fallback; $0 never bypasses.
    always_comb begin
        sel          = SEL_W'(SEL_RF);
        hit          = 1'b0;
        hzd.load_use = 1'b0;
        hzd.md_raw   = 1'b0;
        if (regread && (srcaddr != '0)) begin
            for (int k = 0; k < NUM_FWD_STG; k++) begin
                if (!hit && stg_regwrite[k] &&
                    (stg_wraddr[k*REG_AW +: REG_AW] == srcaddr)) begin
                    hit          = 1'b1;
                    sel          = SEL_W'(k + SEL_STG_OFS);
                    hzd.load_use = stg_notready[k];
                end
            end
            // A pending MDU write only matters if no younger stage overrides it.
            if (!hit && md_busy && (md_addr_q == srcaddr)) begin
                if (md_done) begin
                    sel = SEL_W'(sel_mdu(NUM_FWD_STG));
                end else begin
                    hzd.md_raw = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hzd_sb_unit.sv
// Forwarding / hazard unit beside EX with a one-entry MDU scoreboard.
//
// MDU handshake: an op is accepted on a rising edge where md_issue=1,
// stall=0 and ex_flush=0; md_done is a one-cycle pulse marking the result
// of the outstanding op as valid in that same cycle. A done pulse with no
// op outstanding is ignored. Done and a new accepted issue in one cycle
// retire the old op and capture the new one back to back.
module fwd_hzd_sb_unit
    import fwd_hzd_sb_unit_pkg::*;
#(
    parameter  int NUM_SRC     = 2,
    parameter  int REG_AW      = 5,
    parameter  int NUM_FWD_STG = 2,
    parameter  int PERF_W      = 32,
    localparam int SEL_W       = $clog2(NUM_FWD_STG + 2)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            ex_regread,
    input  logic [NUM_SRC*REG_AW-1:0]     ex_srcaddr,
    input  logic                          ex_flush,
    input  logic [NUM_FWD_STG-1:0]        stg_regwrite,
    input  logic [NUM_FWD_STG*REG_AW-1:0] stg_wraddr,
    input  logic [NUM_FWD_STG-1:0]        stg_notready,
    input  logic                          md_issue,
    input  logic [REG_AW-1:0]             md_wraddr,
    input  logic                          md_done,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic                          md_busy,
    output logic [PERF_W-1:0]             perf_stall
);

    logic [REG_AW-1:0]  md_addr_q;
    logic [NUM_SRC-1:0] load_use_v;
    logic [NUM_SRC-1:0] md_raw_v;
    logic               md_struct;
    logic               md_accept;

    // One lookup per operand; each is gated by its own regread bit.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        src_hzd_t hzd_i;

        fwd_hzd_sb_unit_src_lookup #(
            .NUM_FWD_STG (NUM_FWD_STG),
            .REG_AW      (REG_AW),
            .SEL_W       (SEL_W)
        ) u_lookup (
            .regread      (ex_regread[i]),
            .srcaddr      (ex_srcaddr[i*REG_AW +: REG_AW]),
            .stg_regwrite (stg_regwrite),
            .stg_wraddr   (stg_wraddr),
            .stg_notready (stg_notready),
            .md_busy      (md_busy),
            .md_done      (md_done),
            .md_addr_q    (md_addr_q),
            .sel          (fwd_sel[i*SEL_W +: SEL_W]),
            .hzd          (hzd_i)
        );

        assign load_use_v[i] = hzd_i.load_use;
        assign md_raw_v[i]   = hzd_i.md_raw;
    end

    // Stall terms OR together; a flushed EX slot never stalls and never issues.
    always_comb begin
        md_struct = md_issue && md_busy && !md_done;
        stall     = !ex_flush && ((|load_use_v) || (|md_raw_v) || md_struct);
        md_accept = md_issue && !stall && !ex_flush;
    end

    // MDU scoreboard: capture on accepted issue, retire on done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_busy   <= 1'b0;
            md_addr_q <= '0;
        end else if (md_accept) begin
            md_busy   <= 1'b1;
            md_addr_q <= md_wraddr;
        end else if (md_done && md_busy) begin
            md_busy   <= 1'b0;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
        end else if (stall && (perf_stall != {PERF_W{1'b1}})) begin
            perf_stall <= perf_stall + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_hzd_sb_unit.sv
// Directed bench for fwd_hzd_sb_unit. A narrow perf counter is used so
// saturation is reachable in a handful of cycles.
module tb_fwd_hzd_sb_unit;

  localparam int NUM_SRC     = 2;
  localparam int REG_AW      = 5;
  localparam int NUM_FWD_STG = 2;
  localparam int PERF_W      = 4;
  localparam int SEL_W       = 2;
  localparam logic [SEL_W-1:0] SEL_MDU = 2'd3;
  localparam logic [PERF_W-1:0] PERF_MAX = 4'd15;

  logic                          clk;
  logic                          rst_n;
  logic [NUM_SRC-1:0]            ex_regread;
  logic [NUM_SRC*REG_AW-1:0]     ex_srcaddr;
  logic                          ex_flush;
  logic [NUM_FWD_STG-1:0]        stg_regwrite;
  logic [NUM_FWD_STG*REG_AW-1:0] stg_wraddr;
  logic [NUM_FWD_STG-1:0]        stg_notready;
  logic                          md_issue;
  logic [REG_AW-1:0]             md_wraddr;
  logic                          md_done;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic                          stall;
  logic                          md_busy;
  logic [PERF_W-1:0]             perf_stall;

  int checks;
  int errors;
  logic [PERF_W-1:0] exp_perf;

  fwd_hzd_sb_unit #(
    .NUM_SRC     (NUM_SRC),
    .REG_AW      (REG_AW),
    .NUM_FWD_STG (NUM_FWD_STG),
    .PERF_W      (PERF_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_regread   (ex_regread),
    .ex_srcaddr   (ex_srcaddr),
    .ex_flush     (ex_flush),
    .stg_regwrite (stg_regwrite),
    .stg_wraddr   (stg_wraddr),
    .stg_notready (stg_notready),
    .md_issue     (md_issue),
    .md_wraddr    (md_wraddr),
    .md_done      (md_done),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .md_busy      (md_busy),
    .perf_stall   (perf_stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_idle();
    ex_regread   = '0;
    ex_srcaddr   = '0;
    ex_flush     = 1'b0;
    stg_regwrite = '0;
    stg_wraddr   = '0;
    stg_notready = '0;
    md_issue     = 1'b0;
    md_wraddr    = '0;
    md_done      = 1'b0;
    #1;
  endtask

  // advance one edge; the caller states whether the cycle was a stall cycle
  task automatic tick(input logic exp_st);
    if (exp_st && exp_perf != PERF_MAX) exp_perf = exp_perf + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    exp_perf = '0;
    @(posedge clk);
    #1;
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL reset_fwd_sel got %0h exp 0", fwd_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy got %0b exp 0", md_busy); end
    checks++; if (perf_stall !== 4'd0) begin errors++; $display("FAIL reset_perf got %0d exp 0", perf_stall); end
    rst_n = 1'b1;
    tick(1'b0);
    checks++; if (perf_stall !== 4'd0 || stall !== 1'b0) begin errors++; $display("FAIL idle_after_reset perf %0d stall %0b exp 0 0", perf_stall, stall); end
  endtask

  task automatic test_priority();
    ex_regread   = 2'b11;
    ex_srcaddr   = {5'd5, 5'd5};
    stg_regwrite = 2'b11;
    stg_wraddr   = {5'd5, 5'd5};
    #1;
    checks++; if (fwd_sel !== 4'b0101) begin errors++; $display("FAIL prio_both got %0h exp 5", fwd_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall got %0b exp 0", stall); end
    stg_regwrite = 2'b10;
    #1;
    checks++; if (fwd_sel !== 4'b1010) begin errors++; $display("FAIL prio_stage1 got %0h exp a", fwd_sel); end
    ex_regread = 2'b01;
    #1;
    checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL prio_gate got %0h exp 2", fwd_sel); end
    ex_regread   = 2'b11;
    stg_regwrite = 2'b11;
    stg_wraddr   = {5'd5, 5'd6};
    #1;
    checks++; if (fwd_sel !== 4'b1010) begin errors++; $display("FAIL prio_addr_miss got %0h exp a", fwd_sel); end
    ex_srcaddr = {5'd0, 5'd0};
    stg_wraddr = {5'd0, 5'd0};
    #1;
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL prio_zero_reg got %0h exp 0", fwd_sel); end
    drive_idle();
  endtask

  task automatic test_load_use();
    ex_regread   = 2'b10;
    ex_srcaddr   = {5'd7, 5'd3};
    stg_regwrite = 2'b01;
    stg_wraddr   = {5'd0, 5'd7};
    stg_notready = 2'b01;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b exp 1", stall); end
    checks++; if (fwd_sel !== 4'b0100) begin errors++; $display("FAIL lu_fwd_sel got %0h exp 4", fwd_sel); end
    for (int c = 0; c < 3; c++) begin
      tick(1'b1);
      checks++; if (perf_stall !== exp_perf) begin errors++; $display("FAIL lu_perf got %0d exp %0d", perf_stall, exp_perf); end
    end
    stg_notready = 2'b00;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %0b exp 0", stall); end
    checks++; if (fwd_sel !== 4'b0100) begin errors++; $display("FAIL lu_release_sel got %0h exp 4", fwd_sel); end
    tick(1'b0);
    checks++; if (perf_stall !== 4'd3) begin errors++; $display("FAIL lu_perf_hold got %0d exp 3", perf_stall); end
    drive_idle();
  endtask

  task automatic test_mdu_raw();
    md_issue  = 1'b1;
    md_wraddr = 5'd9;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_issue_stall got %0b exp 0", stall); end
    tick(1'b0);
    md_issue = 1'b0;
    #1;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL raw_busy got %0b exp 1", md_busy); end
    ex_regread = 2'b01;
    ex_srcaddr = {5'd0, 5'd9};
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_wait_stall cycle %0d got %0b exp 1", c, stall); end
      tick(1'b1);
    end
    md_done = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_done_stall got %0b exp 0", stall); end
    checks++; if (fwd_sel[1:0] !== SEL_MDU) begin errors++; $display("FAIL raw_done_sel got %0d exp %0d", fwd_sel[1:0], SEL_MDU); end
    tick(1'b0);
    md_done = 1'b0;
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL raw_retire got %0b exp 0", md_busy); end
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL raw_after_sel got %0h exp 0", fwd_sel); end
    checks++; if (perf_stall !== exp_perf) begin errors++; $display("FAIL raw_perf got %0d exp %0d", perf_stall, exp_perf); end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    md_issue  = 1'b1;
    md_wraddr = 5'd4;
    tick(1'b0);
    md_wraddr = 5'd10;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_struct got %0b exp 1", stall); end
    tick(1'b1);
    md_done = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_done_issue got %0b exp 0", stall); end
    tick(1'b0);
    md_issue = 1'b0;
    md_done  = 1'b0;
    #1;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %0b exp 1", md_busy); end
    ex_regread = 2'b01;
    ex_srcaddr = {5'd0, 5'd10};
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_new_addr got %0b exp 1", stall); end
    ex_srcaddr = {5'd0, 5'd4};
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_old_addr got %0b exp 0", stall); end
    // flushed issue: no stall and not captured
    ex_srcaddr = {5'd0, 5'd10};
    md_issue   = 1'b1;
    md_wraddr  = 5'd12;
    ex_flush   = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b exp 0", stall); end
    tick(1'b0);
    md_issue = 1'b0;
    ex_flush = 1'b0;
    ex_srcaddr = {5'd0, 5'd12};
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_not_captured got %0b exp 0", stall); end
    ex_srcaddr = {5'd0, 5'd10};
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_old_kept got %0b exp 1", stall); end
    md_done = 1'b1;
    #1;
    checks++; if (fwd_sel[1:0] !== SEL_MDU || stall !== 1'b0) begin errors++; $display("FAIL b2b_final_done sel %0d stall %0b exp 3 0", fwd_sel[1:0], stall); end
    tick(1'b0);
    drive_idle();
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL b2b_final_busy got %0b exp 0", md_busy); end
    checks++; if (perf_stall !== exp_perf) begin errors++; $display("FAIL b2b_perf got %0d exp %0d", perf_stall, exp_perf); end
  endtask

  task automatic test_saturation();
    ex_regread   = 2'b01;
    ex_srcaddr   = {5'd0, 5'd2};
    stg_regwrite = 2'b10;
    stg_wraddr   = {5'd2, 5'd0};
    stg_notready = 2'b10;
    #1;
    checks++; if (stall !== 1'b1 || fwd_sel !== 4'b0010) begin errors++; $display("FAIL sat_lu_stage1 stall %0b sel %0h exp 1 2", stall, fwd_sel); end
    for (int c = 0; c < 12; c++) tick(1'b1);
    checks++; if (exp_perf !== PERF_MAX || perf_stall !== PERF_MAX) begin errors++; $display("FAIL sat_perf got %0d exp %0d", perf_stall, PERF_MAX); end
    drive_idle();
  endtask

  task automatic test_reset_mid_op();
    md_issue  = 1'b1;
    md_wraddr = 5'd9;
    tick(1'b0);
    md_issue = 1'b0;
    #1;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got %0b exp 1", md_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_perf = '0;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rmid_async_busy got %0b exp 0", md_busy); end
    checks++; if (perf_stall !== 4'd0) begin errors++; $display("FAIL rmid_async_perf got %0d exp 0", perf_stall); end
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    md_done    = 1'b1;
    ex_regread = 2'b01;
    ex_srcaddr = {5'd0, 5'd9};
    #1;
    checks++; if (fwd_sel !== 4'b0000 || stall !== 1'b0) begin errors++; $display("FAIL rmid_done_ignored sel %0h stall %0b exp 0 0", fwd_sel, stall); end
    tick(1'b0);
    drive_idle();
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_after got %0b exp 0", md_busy); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_perf = '0;
    rst_n    = 1'b0;
    test_reset();
    test_priority();
    test_load_use();
    test_mdu_raw();
    test_back_to_back();
    test_saturation();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
